// File: rtl/fpa_ui_pkg.sv
// Shared types and constants for the FPA keypad/display front end:
// sequencer states, keypad codes and active-low 7-segment glyphs.
package fpa_ui_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENT_A = 3'd1,
    ST_ENT_B = 3'd2,
    ST_CALC  = 3'd3,
    ST_SHOW  = 3'd4
  } state_e;

  localparam logic [4:0] KEY_BKSP  = 5'h10;
  localparam logic [4:0] KEY_ENTER = 5'h11;
  localparam logic [4:0] KEY_CLR   = 5'h12;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_E     = 8'h86;

  // Segment order is {dp,g,f,e,d,c,b,a}, all active low, dp off.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_enc.sv
// Combinational hex nibble to active-low 7-segment glyph encoder.
module seg7_enc
  import fpa_ui_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  assign seg = hex_glyph(nib);

endmodule

// File: rtl/fpa_entry_ctrl.sv
// Keypad entry / display sequencer for the FPA core: two hex operands, start/done
// handshake with timeout, registered 7-segment drive. Optional macro STATUS_DP_EN.
module fpa_entry_ctrl
  import fpa_ui_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int DISP    = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [4:0]            key,
  output logic                  fpa_start,
  output logic [4*DIGITS-1:0]   op_a,
  output logic [4*DIGITS-1:0]   op_b,
  input  logic                  fpa_done,
  input  logic [4*DIGITS-1:0]   fpa_result,
  output logic [4*DIGITS-1:0]   res_q,
  output logic                  err,
  output logic [1:0]            out_st,
  output logic [8*DISP-1:0]     seg
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("fpa_entry_ctrl: DIGITS must be within 1..8");
  end
  if (DISP < DIGITS + 1) begin : g_bad_disp
    $error("fpa_entry_ctrl: DISP must be at least DIGITS+1");
  end

  state_e          state_q, state_d;
  logic [W-1:0]    op_a_q, op_a_d, op_b_q, op_b_d, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            fpa_start_q, fpa_start_d;
  logic [8*DISP-1:0] seg_q, seg_d;

  logic [W-1:0]    cur_op, ent_op;
  logic            is_digit, is_bksp, is_enter, is_clr, in_entry;

  assign is_digit = key_valid && !key[4];
  assign is_bksp  = key_valid && (key == KEY_BKSP);
  assign is_enter = key_valid && (key == KEY_ENTER);
  assign is_clr   = key_valid && (key == KEY_CLR);
  assign in_entry = (state_q == ST_ENT_A) || (state_q == ST_ENT_B);
  assign cur_op   = (state_q == ST_ENT_B) ? op_b_q : op_a_q;

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    ent_op  = cur_op;

    case (state_q)
      ST_IDLE: begin
        // The waking key only opens entry; fresh operands start from zero.
        if (key_valid && !is_clr) begin
          state_d = ST_ENT_A;
          cnt_d   = '0;
          op_a_d  = '0;
          op_b_d  = '0;
        end
      end
      ST_ENT_A, ST_ENT_B: begin
        if (is_digit && cnt_q != CNT_FULL) begin
          ent_op = (cur_op << 4) | W'(key[3:0]);
          cnt_d  = cnt_q + CW'(1);
        end else if (is_bksp && cnt_q != '0) begin
          ent_op = cur_op >> 4;
          cnt_d  = cnt_q - CW'(1);
        end else if (is_enter && cnt_q != '0) begin
          if (state_q == ST_ENT_A) begin
            state_d = ST_ENT_B;
            cnt_d   = '0;
          end else begin
            state_d = ST_CALC;
            tmo_d   = '0;
          end
        end
        if (state_q == ST_ENT_A) op_a_d = ent_op;
        else                     op_b_d = ent_op;
      end
      ST_CALC: begin
        if (fpa_done) begin
          res_d   = fpa_result;
          state_d = ST_SHOW;
        end else if (TIMEOUT != 0 && tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_SHOW;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_SHOW: begin
        if (is_enter) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a result arriving this cycle.
    if (is_clr && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      op_a_d  = '0;
      op_b_d  = '0;
      res_d   = '0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  assign fpa_start_d = (state_d == ST_CALC) && (state_q != ST_CALC);

  always_comb begin
    case (state_q)
      ST_IDLE:  out_st = 2'b00;
      ST_ENT_A: out_st = 2'b01;
      ST_ENT_B: out_st = 2'b10;
      default:  out_st = 2'b11;
    endcase
  end

  for (genvar gi = 0; gi < DISP; gi++) begin : g_disp
    if (gi < DIGITS) begin : g_digit
      logic [3:0] nib;
      logic [7:0] enc, glyph;
      assign nib = (state_q == ST_SHOW) ? res_q[4*gi +: 4] : cur_op[4*gi +: 4];
      seg7_enc u_enc (
        .nib (nib),
        .seg (enc)
      );
      assign glyph = (in_entry && (CW'(gi) < cnt_q)) ? enc :
                     (state_q == ST_SHOW)             ? (err_q ? SEG_E : enc) :
                                                        SEG_BLANK;
`ifdef STATUS_DP_EN
      if (gi == 0) begin : g_full_dp
        assign seg_d[8*gi +: 8] = (in_entry && cnt_q == CNT_FULL) ?
                                  {1'b0, glyph[6:0]} : glyph;
      end else begin : g_plain
        assign seg_d[8*gi +: 8] = glyph;
      end
`else
      assign seg_d[8*gi +: 8] = glyph;
`endif
    end else if (gi == DISP - 1) begin : g_tag
      logic [7:0] tag;
      assign tag = (state_q == ST_ENT_A) ? SEG_A :
                   (state_q == ST_ENT_B) ? SEG_B : SEG_BLANK;
`ifdef STATUS_DP_EN
      assign seg_d[8*gi +: 8] = (state_q == ST_CALC) ? {1'b0, tag[6:0]} : tag;
`else
      assign seg_d[8*gi +: 8] = tag;
`endif
    end else begin : g_blank
      assign seg_d[8*gi +: 8] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      fpa_start_q <= 1'b0;
      seg_q       <= {DISP{SEG_BLANK}};
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      fpa_start_q <= fpa_start_d;
      seg_q       <= seg_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign err       = err_q;
  assign fpa_start = fpa_start_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_fpa_entry_ctrl.sv
// Bench for fpa_entry_ctrl: directed scenarios followed by random keypad/done
// traffic, all checked against a digit-queue reference model every cycle.
module tb_fpa_entry_ctrl;

  localparam int DIGITS  = 4;
  localparam int DISP    = 6;
  localparam int TIMEOUT = 8;
  localparam int W       = 4 * DIGITS;

  localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              key_valid = 1'b0;
  logic [4:0]        key = '0;
  logic              fpa_done = 1'b0;
  logic [W-1:0]      fpa_result = '0;
  logic              fpa_start, err;
  logic [W-1:0]      op_a, op_b, res_q;
  logic [1:0]        out_st;
  logic [8*DISP-1:0] seg;

  always #5 clk = ~clk;

  fpa_entry_ctrl #(.DIGITS(DIGITS), .DISP(DISP), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key        (key),
    .fpa_start  (fpa_start),
    .op_a       (op_a),
    .op_b       (op_b),
    .fpa_done   (fpa_done),
    .fpa_result (fpa_result),
    .res_q      (res_q),
    .err        (err),
    .out_st     (out_st),
    .seg        (seg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 0 idle, 1 entering A, 2 entering B, 3 calc, 4 show.
  int                m_st = 0;
  logic [3:0]        dig_a[$];
  logic [3:0]        dig_b[$];
  logic [W-1:0]      m_res = '0;
  logic              m_err = 1'b0;
  int                m_calc = 0;
  logic              m_start = 1'b0;
  logic [8*DISP-1:0] m_seg = '1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] q_val(input logic [3:0] q[$]);
    logic [W-1:0] v;
    v = '0;
    foreach (q[i]) v = (v << 4) | W'(q[i]);
    return v;
  endfunction

  function automatic logic [1:0] exp_out_st(input int st);
    return (st >= 3) ? 2'b11 : 2'(st);
  endfunction

  function automatic logic [8*DISP-1:0] m_display();
    logic [8*DISP-1:0] s;
    logic [3:0]        q[$];
    s = '1;
    if (m_st == 1 || m_st == 2) begin
      if (m_st == 1) q = dig_a;
      else           q = dig_b;
      for (int i = 0; i < q.size(); i++) s[8*i +: 8] = GLYPH[q[q.size()-1-i]];
      s[8*(DISP-1) +: 8] = (m_st == 1) ? 8'h88 : 8'h83;
    end else if (m_st == 4) begin
      for (int i = 0; i < DIGITS; i++) s[8*i +: 8] = m_err ? 8'h86 : GLYPH[m_res[4*i +: 4]];
    end
    return s;
  endfunction

  task automatic model_step(input logic r, input logic kv, input logic [4:0] k,
                            input logic d, input logic [W-1:0] res);
    int         st0;
    logic [3:0] q[$];
    if (!r) begin
      m_st = 0; dig_a.delete(); dig_b.delete();
      m_res = '0; m_err = 1'b0; m_calc = 0; m_start = 1'b0; m_seg = '1;
      return;
    end
    st0     = m_st;
    m_seg   = m_display();
    m_start = 1'b0;
    case (st0)
      0: if (kv && k != 5'h12) begin
        m_st = 1; dig_a.delete(); dig_b.delete();
      end
      1, 2: begin
        if (st0 == 1) q = dig_a;
        else          q = dig_b;
        if (kv && k < 5'h10) begin
          if (q.size() < DIGITS) q.push_back(k[3:0]);
        end else if (kv && k == 5'h10) begin
          if (q.size() > 0) void'(q.pop_back());
        end else if (kv && k == 5'h11 && q.size() > 0) begin
          if (st0 == 1) m_st = 2;
          else begin m_st = 3; m_calc = 0; m_start = 1'b1; end
        end
        if (st0 == 1) dig_a = q;
        else          dig_b = q;
      end
      3: begin
        if (d) begin m_res = res; m_st = 4; end
        else begin
          m_calc++;
          if (m_calc == TIMEOUT) begin m_err = 1'b1; m_st = 4; end
        end
      end
      default: if (kv && k == 5'h11) m_st = 0;
    endcase
    if (kv && k == 5'h12 && st0 != 0) begin
      m_st = 0; dig_a.delete(); dig_b.delete(); m_res = '0; m_err = 1'b0;
    end
  endtask

  task automatic cyc(input logic r, input logic kv, input logic [4:0] k,
                     input logic d, input logic [W-1:0] res);
    @(negedge clk);
    rst = r; key_valid = kv; key = k; fpa_done = d; fpa_result = res;
    @(posedge clk);
    model_step(r, kv, k, d, res);
    #1;
    check_eq("out_st", 64'(out_st), 64'(exp_out_st(m_st)));
    check_eq("op_a", 64'(op_a), 64'(q_val(dig_a)));
    check_eq("op_b", 64'(op_b), 64'(q_val(dig_b)));
    check_eq("res_q", 64'(res_q), 64'(m_res));
    check_eq("err", 64'(err), 64'(m_err));
    check_eq("fpa_start", 64'(fpa_start), 64'(m_start));
    check_eq("seg", 64'(seg), 64'(m_seg));
  endtask

  task automatic press(input logic [4:0] k);
    cyc(1'b1, 1'b1, k, 1'b0, '0);
    $display("key %h -> out_st %b op_a %h op_b %h res %h err %b", k, out_st, op_a, op_b, res_q, err);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 5'h00, 1'b0, '0);
  endtask

  initial begin
    logic       kv, d, r;
    logic [4:0] k;
    int         sel;

    cyc(1'b0, 1'b0, 5'h00, 1'b0, '0);
    cyc(1'b0, 1'b0, 5'h00, 1'b0, '0);
    check_eq("rst_out_st", 64'(out_st), 64'd0);
    check_eq("rst_seg", 64'(seg), 64'h0000_FFFF_FFFF_FFFF);
    check_eq("rst_start", 64'(fpa_start), 64'd0);

    // Full two-operand entry and a completed calculation.
    press(5'h07);
    check_eq("wake_st", 64'(out_st), 64'd1);
    press(5'h03); press(5'h0C); press(5'h00); press(5'h00);
    press(5'h11);
    check_eq("opa_3c00", 64'(op_a), 64'h3C00);
    check_eq("entb_st", 64'(out_st), 64'd2);
    press(5'h04); press(5'h00); press(5'h00); press(5'h00);
    press(5'h11);
    check_eq("opb_4000", 64'(op_b), 64'h4000);
    check_eq("calc_st", 64'(out_st), 64'd3);
    check_eq("start_hi", 64'(fpa_start), 64'd1);
    idle(1);
    check_eq("start_lo", 64'(fpa_start), 64'd0);
    cyc(1'b1, 1'b0, 5'h00, 1'b1, 16'h4200);
    check_eq("res_4200", 64'(res_q), 64'h4200);
    idle(1);
    check_eq("show_digits", 64'(seg[31:0]), 64'h99A4_C0C0);
    press(5'h11);
    check_eq("show_exit", 64'(out_st), 64'd0);

    // Clear colliding with fpa_done discards the result.
    press(5'h05); press(5'h01); press(5'h11); press(5'h02); press(5'h11);
    cyc(1'b1, 1'b1, 5'h12, 1'b1, 16'h1234);
    check_eq("clr_done_st", 64'(out_st), 64'd0);
    check_eq("clr_done_res", 64'(res_q), 64'd0);

    // Boundary keys, backspace and partial entry.
    press(5'h05);
    press(5'h10); press(5'h11);
    check_eq("empty_keys_st", 64'(out_st), 64'd1);
    check_eq("empty_keys_op", 64'(op_a), 64'd0);
    press(5'h01); press(5'h02); press(5'h10); press(5'h07);
    check_eq("opa_0017", 64'(op_a), 64'h0017);
    idle(1);
    check_eq("disp0_7", 64'(seg[7:0]), 64'hF8);
    check_eq("disp1_1", 64'(seg[15:8]), 64'hF9);
    check_eq("disp23_blank", 64'(seg[31:16]), 64'hFFFF);
    check_eq("disp5_A", 64'(seg[47:40]), 64'h88);
    press(5'h02); press(5'h03); press(5'h09);
    check_eq("fifth_digit", 64'(op_a), 64'h1723);
    press(5'h11); press(5'h04);
    cyc(1'b0, 1'b0, 5'h00, 1'b0, '0);
    check_eq("midrst_st", 64'(out_st), 64'd0);
    check_eq("midrst_opb", 64'(op_b), 64'd0);
    check_eq("midrst_seg", 64'(seg), 64'h0000_FFFF_FFFF_FFFF);

    // Timeout path.
    press(5'h05); press(5'h01); press(5'h11); press(5'h02); press(5'h11);
    idle(7);
    check_eq("tmo_err_lo", 64'(err), 64'd0);
    idle(1);
    check_eq("tmo_err_hi", 64'(err), 64'd1);
    check_eq("tmo_st", 64'(out_st), 64'd3);
    idle(1);
    check_eq("tmo_disp_E", 64'(seg[31:0]), 64'h8686_8686);
    press(5'h12);
    check_eq("tmo_clr_err", 64'(err), 64'd0);
    check_eq("tmo_clr_st", 64'(out_st), 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      kv  = ($urandom_range(0, 99) < 40);
      sel = $urandom_range(0, 99);
      if (sel < 55)      k = 5'($urandom_range(0, 15));
      else if (sel < 70) k = 5'h10;
      else if (sel < 86) k = 5'h11;
      else if (sel < 90) k = 5'h12;
      else               k = 5'($urandom_range(19, 31));
      d = ($urandom_range(0, 99) < 8);
      r = ($urandom_range(0, 499) != 0);
      cyc(r, kv, k, d, W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
